// File: rtl/math_regfile.sv
// Per-thread math register file: registered read port with write bypass,
// freeze-gated writeback, and a req/ack host port that keeps working while frozen.
module math_regfile #(
  parameter int DATA_W  = 18,
  parameter int ADDR_W  = 6,
  parameter int STALL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              wr_we,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdat,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdat,
  output logic [STALL_W-1:0] ext_stall_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DONE = 1'b1;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic              math_commit;
  logic              ext_granted;
  logic              ext_idle_req;
  logic              ext_commit;
  logic              ext_read;
  logic              ext_blocked;
  logic [DATA_W-1:0] rd_next;

  // Math writeback owns the port unless it is frozen or idle, so the two
  // commits can never target the same entry on the same edge.
  assign math_commit  = wr_we & ~freeze;
  assign ext_granted  = freeze | ~wr_we;
  assign ext_idle_req = (state == IDLE) & ext_req;
  assign ext_commit   = ext_idle_req & ext_we & ext_granted;
  assign ext_read     = ext_idle_req & ~ext_we;
  assign ext_blocked  = ext_idle_req & ext_we & ~ext_granted;

  always_comb begin
    rd_next = mem[rd_addr];
    if (math_commit && (wr_addr == rd_addr)) begin
      rd_next = wr_dat;
    end else if (ext_commit && (ext_addr == rd_addr)) begin
      rd_next = ext_wdat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (math_commit) begin
        mem[wr_addr] <= wr_dat;
      end
      if (ext_commit) begin
        mem[ext_addr] <= ext_wdat;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_dat <= '0;
    end else if (!freeze) begin
      rd_dat <= rd_next;
    end
  end

  // DONE waits for the host to drop req so a held request is serviced once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ext_ack       <= 1'b0;
      ext_rdat      <= '0;
      ext_stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          ext_ack <= 1'b0;
          if (ext_commit || ext_read) begin
            ext_ack <= 1'b1;
            state   <= DONE;
          end
          if (ext_read) begin
            ext_rdat <= mem[ext_addr];
          end
          if (ext_blocked && (ext_stall_cnt != STALL_MAX)) begin
            ext_stall_cnt <= ext_stall_cnt + 1'b1;
          end
        end
        DONE: begin
          ext_ack <= 1'b0;
          if (!ext_req) begin
            state <= IDLE;
          end
        end
        default: begin
          ext_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_math_regfile.sv
// Self-checking bench for math_regfile: directed scenarios pinned by literal
// values, then randomized traffic checked every cycle against an array model.
module tb_math_regfile;

  localparam int DATA_W  = 18;
  localparam int ADDR_W  = 6;
  localparam int STALL_W = 8;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int STALL_SAT = 2 ** STALL_W - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              freeze;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_dat;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_dat;
  logic              wr_we;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdat;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdat;
  logic [STALL_W-1:0] ext_stall_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  math_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .rd_addr(rd_addr), .rd_dat(rd_dat),
    .wr_addr(wr_addr), .wr_dat(wr_dat), .wr_we(wr_we),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdat(ext_wdat),
    .ext_ack(ext_ack), .ext_rdat(ext_rdat), .ext_stall_cnt(ext_stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a plain array plus "host already answered" flag.
  int m_mem [DEPTH];
  int m_rd, m_rdat, m_stall;
  bit m_ack, m_answered;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      m_rd = 0; m_rdat = 0; m_stall = 0; m_ack = 0; m_answered = 0;
    end else begin
      bit math_wr, host_wr;
      int new_rd;
      math_wr = wr_we && !freeze;
      host_wr = 0;
      m_ack = 0;
      if (m_answered) begin
        if (!ext_req) m_answered = 0;
      end else if (ext_req) begin
        if (!ext_we) begin
          m_rdat = m_mem[ext_addr];
          m_ack = 1; m_answered = 1;
        end else if (freeze || !wr_we) begin
          host_wr = 1;
          m_ack = 1; m_answered = 1;
        end else if (m_stall < STALL_SAT) begin
          m_stall = m_stall + 1;
        end
      end
      new_rd = m_mem[rd_addr];
      if (math_wr && wr_addr == rd_addr) new_rd = int'(wr_dat);
      if (host_wr && ext_addr == rd_addr) new_rd = int'(ext_wdat);
      if (!freeze) m_rd = new_rd;
      if (math_wr) m_mem[wr_addr] = int'(wr_dat);
      if (host_wr) m_mem[ext_addr] = int'(ext_wdat);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_rd_dat", 32'(rd_dat), 32'(m_rd));
      checkOutput("model_ext_ack", 32'(ext_ack), 32'(m_ack));
      checkOutput("model_ext_rdat", 32'(ext_rdat), 32'(m_rdat));
      checkOutput("model_stall", 32'(ext_stall_cnt), 32'(m_stall));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    bit acked;
    acked = 0;
    for (int c = 0; c < 3000; c++) begin
      freeze   = ($urandom_range(0, 3) == 0);
      wr_we    = 1'($urandom_range(0, 1));
      wr_addr  = ADDR_W'($urandom);
      wr_dat   = DATA_W'($urandom);
      rd_addr  = ADDR_W'($urandom);
      if (!ext_req) begin
        if ($urandom_range(0, 2) == 0) begin
          ext_req  = 1'b1;
          ext_we   = 1'($urandom_range(0, 1));
          ext_addr = ADDR_W'($urandom);
          ext_wdat = DATA_W'($urandom);
          acked    = 0;
        end
      end else if (acked && $urandom_range(0, 1) == 1) begin
        ext_req = 1'b0;
      end
      reset = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      tick();
      if (ext_ack) acked = 1;
      if (!reset) acked = 0;
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; freeze = 0; rd_addr = '0; wr_addr = '0; wr_dat = '0; wr_we = 0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdat = '0;
    repeat (3) tick();
    reset = 1'b1;
    chk_en = 1'b1;

    // Reset value and 1-cycle read latency
    rd_addr = 6'd5;
    tick();
    checkOutput("reset_rd5", 32'(rd_dat), 32'h0);
    checkOutput("reset_stall", 32'(ext_stall_cnt), 32'h0);
    wr_addr = 6'd5; wr_dat = 18'h00ABC; wr_we = 1;
    tick();
    wr_we = 0; rd_addr = 6'd5;
    tick();
    checkOutput("read5", 32'(rd_dat), 32'h00ABC);
    checkOutput("pin_model_read5", 32'(m_rd), 32'h00ABC);

    // Bypass
    wr_addr = 6'd12; wr_dat = 18'h3FFFF; wr_we = 1; rd_addr = 6'd12;
    tick();
    checkOutput("bypass12", 32'(rd_dat), 32'h3FFFF);
    wr_we = 0;

    // Freeze holds rd_dat and drops math writes
    wr_addr = 6'd7; wr_dat = 18'h00010; wr_we = 1; rd_addr = 6'd7;
    tick();
    checkOutput("preload7", 32'(rd_dat), 32'h00010);
    freeze = 1; wr_dat = 18'h00022; rd_addr = 6'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("freeze_hold", 32'(rd_dat), 32'h00010);
    end
    freeze = 0; wr_we = 0; rd_addr = 6'd7;
    tick();
    checkOutput("frozen_write_dropped", 32'(rd_dat), 32'h00010);

    // Host write handshake, single ack for held request, host readback
    ext_req = 1; ext_we = 1; ext_addr = 6'd40; ext_wdat = 18'h12345;
    tick();
    checkOutput("host_wr_ack", 32'(ext_ack), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_second_ack", 32'(ext_ack), 32'h0);
    end
    ext_req = 0;
    tick();
    ext_req = 1; ext_we = 0; ext_addr = 6'd40;
    tick();
    checkOutput("host_rd_ack", 32'(ext_ack), 32'h1);
    checkOutput("host_rd40", 32'(ext_rdat), 32'h12345);
    checkOutput("pin_model_rdat", 32'(m_rdat), 32'h12345);
    ext_req = 0;
    tick();

    // Arbitration: math writeback blocks the host write for 5 cycles
    wr_we = 1; wr_addr = 6'd20; wr_dat = 18'h00777;
    ext_req = 1; ext_we = 1; ext_addr = 6'd9; ext_wdat = 18'h0BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("blocked_no_ack", 32'(ext_ack), 32'h0);
    end
    checkOutput("stall5", 32'(ext_stall_cnt), 32'h5);
    checkOutput("pin_model_stall5", 32'(m_stall), 32'h5);
    wr_we = 0;
    tick();
    checkOutput("unblocked_ack", 32'(ext_ack), 32'h1);
    ext_req = 0; rd_addr = 6'd9;
    tick();
    tick();
    checkOutput("mem9_host", 32'(rd_dat), 32'h0BEEF);

    // Reset in the middle of a blocked host write
    wr_we = 1; ext_req = 1; ext_we = 1; ext_addr = 6'd9; ext_wdat = 18'h01111;
    tick();
    tick();
    reset = 0;
    #1;
    checkOutput("midreset_ack", 32'(ext_ack), 32'h0);
    checkOutput("midreset_stall", 32'(ext_stall_cnt), 32'h0);
    tick();
    reset = 1; wr_we = 0; ext_req = 1; ext_we = 0; ext_addr = 6'd9; rd_addr = 6'd9;
    tick();
    checkOutput("post_reset_ack", 32'(ext_ack), 32'h1);
    checkOutput("post_reset_mem9", 32'(ext_rdat), 32'h0);
    checkOutput("post_reset_rd9", 32'(rd_dat), 32'h0);
    ext_req = 0;
    tick();

    // Stall counter saturation
    wr_we = 1; wr_addr = 6'd1; ext_req = 1; ext_we = 1; ext_addr = 6'd2; ext_wdat = 18'h00055;
    repeat (STALL_SAT + 5) tick();
    checkOutput("stall_saturate", 32'(ext_stall_cnt), 32'(STALL_SAT));
    wr_we = 0;
    tick();
    checkOutput("sat_ack", 32'(ext_ack), 32'h1);
    ext_req = 0;
    tick();

    applyStimulus();
    freeze = 0; wr_we = 0; ext_req = 0;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/math_regfile.md
Name: math_regfile

Overview:
- Per-thread register file that answers the math pipeline's read and writeback requests.
- Read port: registered 1-cycle read, write-to-read bypass.
- Write port: commits writeback only when unfrozen.
- Secondary host/DMA port (ext_*) with a req/ack 4-phase handshake loads inputs and drains outputs, including while the pipeline is frozen.
- Address format: {superscalar_thread, register_index}.

Parameters:
- DATA_W, 18, register data width
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries
- STALL_W, 8, width of the ext stall counter

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- freeze  input  1  global pipeline freeze, same signal the math pipeline uses
- rd_addr  input  ADDR_W  math read address
- rd_dat  output  DATA_W  math read data, valid one cycle after rd_addr is sampled
- wr_addr  input  ADDR_W  math writeback address
- wr_dat  input  DATA_W  math writeback data
- wr_we  input  1  math writeback enable
- ext_req  input  1  host request, held until ext_ack is seen
- ext_we  input  1  1 = write, 0 = read; stable while ext_req is high
- ext_addr  input  ADDR_W  host address
- ext_wdat  input  DATA_W  host write data
- ext_ack  output  1  one-cycle completion pulse
- ext_rdat  output  DATA_W  host read data, valid in the ext_ack cycle, held until the next ack
- ext_stall_cnt  output  STALL_W  saturating count of cycles a host write was blocked

Behaviour:
- Reset (reset=0, asynchronous):
  - All DEPTH entries = 0; rd_dat = 0; ext_ack = 0; ext_rdat = 0; ext_stall_cnt = 0.
  - FSM returns to IDLE.
  - Reset mid-handshake aborts the operation: no write commits, no ack is issued.
- Math write commit: wr_we & !freeze -> mem[wr_addr] <= wr_dat on the edge. While freeze=1, math writes are ignored.
- Math read:
  - If !freeze: rd_dat <= mem[rd_addr].
  - If freeze: rd_dat holds its value.
  - Latency is exactly 1 clock.
- Bypass: the value captured into rd_dat is the data committing to rd_addr on that same edge (math write or granted ext write), never the stale entry.
- Ext grant rule: a host write is granted when freeze | !wr_we. The math writeback always has priority, and a same-address collision cannot occur.
- Ext reads are always granted and read combinationally from the array, pre-write value. A same-cycle math write to that address is not visible to the ext read.
- FSM IDLE:
  - If ext_req & granted: perform the op (write commits on this edge, or ext_rdat <= mem[ext_addr]), ext_ack <= 1, go DONE.
  - If ext_req & ext_we & !granted: stay IDLE; ext_stall_cnt increments, saturating at 2**STALL_W-1.
- FSM DONE:
  - ext_ack <= 0.
  - Stay until ext_req = 0, then go IDLE.
  - A req held high after the ack is therefore not serviced twice.
- ext_stall_cnt clears only on reset.
- Simultaneous math and ext writes to different addresses when freeze=1: only the ext write commits, because the math write is frozen.
- No X propagation: an out-of-range address is impossible because DEPTH = 2**ADDR_W.

Test Plan:
- Reset/read latency: assert reset=0 for 3 cycles, release; drive rd_addr=5 -> rd_dat=0 next cycle. Write wr_addr=5, wr_dat=18'h00ABC, wr_we=1 for 1 cycle; then rd_addr=5 -> rd_dat=0x00ABC exactly 1 cycle later.
- Bypass: same cycle wr_addr=12, wr_dat=0x3FFFF, wr_we=1, rd_addr=12, freeze=0 -> next cycle rd_dat=0x3FFFF.
- Freeze:
  - Preload mem[7]=0x00010, rd_dat holding 0x00010.
  - With freeze=1: wr_we=1, wr_addr=7, wr_dat=0x00022, rd_addr=3 for 4 cycles -> rd_dat stays 0x00010.
  - Release freeze with wr_we=0, read 7 -> 0x00010 (frozen write dropped).
- Host handshake:
  - ext_req=1, ext_we=1, ext_addr=40, ext_wdat=0x12345, wr_we=0 -> ext_ack pulses 1 cycle.
  - Hold req 3 more cycles -> no second ack.
  - Drop req, then read addr 40 via ext -> ext_rdat=0x12345 with ack.
- Arbitration/stall:
  - freeze=0, wr_we=1 for 5 cycles while a host write to addr 9 is pending -> no ack for 5 cycles, ext_stall_cnt=5.
  - Drop wr_we -> ack next edge, mem[9] holds the host data.
- Reset mid-op: host write pending and blocked by wr_we; pulse reset=0 -> ext_ack stays 0, FSM returns to IDLE, mem[9]=0, ext_stall_cnt=0.
